// File: rtl/decoder_pkg.sv
// Shared types and constants for the 2-to-4 stream decoder: state enum,
// one-hot output words and the code-to-one-hot mapping.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [3:0] D1_ONEHOT = 4'b0001;
  localparam logic [3:0] D2_ONEHOT = 4'b0010;
  localparam logic [3:0] D3_ONEHOT = 4'b0100;
  localparam logic [3:0] D4_ONEHOT = 4'b1000;

  function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
    logic [3:0] word;
    word = '0;
    case (code)
      2'b00: word = D1_ONEHOT;
      2'b01: word = D2_ONEHOT;
      2'b10: word = D3_ONEHOT;
      2'b11: word = D4_ONEHOT;
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small FIFO for 2-bit codes; DEPTH must be a power of two so the pointers
// wrap naturally. Flush empties it and wins over push and pop.
module code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] wr_data,
  output logic [1:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/decoder2x4_stream.sv
// Buffered 2-to-4 decoder: each code is shown one-hot for HOLD_CYCLES cycles.
// Optional decode counter enabled by macro DECODER2X4_STREAM_STATS_EN.
module decoder2x4_stream
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x,
  input  logic       y,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       d4,
  output logic       busy
`ifdef DECODER2X4_STREAM_STATS_EN
  ,
  output logic [7:0] decode_count
`endif
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] word_q, word_d;
  logic       fifo_full, fifo_empty, push, pop;
  logic [1:0] head;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !flush;

  code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data ({x, y}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = HOLD;
            word_d  = code_to_onehot(head);
            cnt_d   = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!fifo_empty) begin
            // reload straight away so consecutive words have no idle gap
            pop    = 1'b1;
            word_d = code_to_onehot(head);
            cnt_d  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
            word_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign d1   = word_q[0];
  assign d2   = word_q[1];
  assign d3   = word_q[2];
  assign d4   = word_q[3];
  assign busy = (state_q == HOLD) || !fifo_empty;

`ifdef DECODER2X4_STREAM_STATS_EN
  logic [7:0] decode_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      decode_cnt_q <= '0;
    else if (flush)  decode_cnt_q <= '0;
    else if (pop)    decode_cnt_q <= decode_cnt_q + 1'b1;
  end

  assign decode_count = decode_cnt_q;
`endif

endmodule

// File: doc/decoder2x4_stream.md
DECODER2X4_STREAM -- requirements
Module: decoder2x4_stream

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles each decoded one-hot word is held on the outputs (legal 1..255).
REQ-002 Parameter: FIFO_DEPTH, default 4, code buffer entries (power of two, 2..16).
REQ-003 Clock `clk` and reset `rst_n`: one clock, rising-edge; reset is asynchronous and active-low.
REQ-004 Ports, listed as name  direction  width  meaning:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- x  in  1  code MSB
- y  in  1  code LSB
- in_valid  in  1  code {x,y} offered
- in_ready  out  1  buffer can accept
- flush  in  1  sync clear of buffer and output
- d1  out  1  one-hot output, code 00
- d2  out  1  one-hot output, code 01
- d3  out  1  one-hot output, code 10
- d4  out  1  one-hot output, code 11
- busy  out  1  hold in progress or buffer non-empty

Function
REQ-005 Mapping SHALL be {x,y}=00->d1, 01->d2, 10->d3, 11->d4; at most one of d1..d4 SHALL be high in any cycle.
REQ-006 A code SHALL be accepted on a rising edge where in_valid && in_ready, and written to the FIFO tail.
REQ-007 in_ready SHALL equal !full, combinational from registered occupancy; there is no pass-through when full, even if a pop happens in the same cycle.
REQ-008 FSM states: IDLE (d1..d4 = 0) and HOLD (one output high, hold counter running).
REQ-009 IDLE->HOLD: on an edge where the FIFO is non-empty, pop the head, register the one-hot word, and load the counter with HOLD_CYCLES-1.
REQ-010 Latency: a code accepted at edge N into an empty FIFO while IDLE SHALL appear on the outputs after edge N+1.
REQ-011 HOLD: decrement the counter each edge; at counter==0, if the FIFO is non-empty, pop and load the next word with no zero gap (stay HOLD); otherwise clear the outputs and go to IDLE.
REQ-012 Each code SHALL be visible for exactly HOLD_CYCLES cycles; codes SHALL leave in FIFO order.
REQ-013 Simultaneous push and pop SHALL keep occupancy unchanged. Pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL be FIFO_DEPTH+1 states wide.
REQ-014 flush SHALL have priority over push and pop. On the next edge it empties the FIFO, zeroes d1..d4, and enters IDLE; a code offered in the flush cycle is dropped.
REQ-015 busy = (state==HOLD) || !empty.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, counter=0, FIFO empty, and d1..d4=0, which gives busy=0 and in_ready=1.
REQ-017 Reset mid-HOLD SHALL discard the current word and all buffered codes; operation resumes on the first edge after deassertion.

Configuration
REQ-018 Macro DECODER2X4_STREAM_STATS_EN defined: adds output `decode_count` (out, 8 bits), incremented on every pop, wrapping 255->0, cleared by reset and flush.
REQ-019 Macro undefined: no `decode_count` port and no counter logic; all other behaviour is identical.

Structure
REQ-020 A shared package `decoder_pkg` SHALL hold the state enum (IDLE, HOLD), the one-hot constants D1_ONEHOT..D4_ONEHOT, and the function mapping a 2-bit code to a 4-bit one-hot word.
REQ-021 The FIFO SHALL be a sub-module `code_fifo` (parameter DEPTH, 2-bit data, push/pop/flush, full/empty); the FSM, counter and output register stay in the top.

Verification
REQ-022 Reset, then push 00 at edge 1 with HOLD_CYCLES=4 -> d1=1 on cycles 2..5, then all zero, IDLE, busy=0.
REQ-023 Back-to-back push 01, 10, 11 -> d2 for 4 cycles, then d3 for 4, then d4 for 4, with no zero cycle between words.
REQ-024 Push 6 codes while the first is held, FIFO_DEPTH=4 -> in_ready=0 after 4 buffered; the 6th is accepted only after a pop; all 6 decode in order.
REQ-025 flush asserted in the 2nd hold cycle with 2 codes buffered -> outputs zero next cycle, busy=0, buffered codes never appear.
REQ-026 rst_n pulsed low mid-HOLD -> outputs zero immediately (asynchronous); after release, pushing 11 gives d4 one cycle later.
REQ-027 With DECODER2X4_STREAM_STATS_EN defined, 257 decodes -> decode_count=1; flush -> 0.
